reset_conditioner: RTL and testbench

RESET_CONDITIONER -- requirements
Module: reset_conditioner

---
 rtl/reset_conditioner.sv | 169 ++++++++++++++++
 tb/tb_reset_conditioner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_conditioner.sv
// reset_conditioner
//   Conditions a pushbutton/polarity reset request and a PLL lock into a
//   clean, registered active-low reset for the downstream core.
//   The request is synchronised, debounced, and sequenced through an FSM:
//   wait for lock, let lock settle, hold reset, then run.
//
// Ports
//   clk          in   system clock; every flop is rising-edge
//   reset_n      in   asynchronous active-low reset
//   pll_locked   in   PLL lock, asynchronous to clk
//   key_n        in   pushbutton, low when pressed, bouncing
//   sw_pol       in   request polarity switch, asynchronous
//   rst_out_n    out  registered reset to the core, 1 = run
//   state        out  FSM state (0 WAIT_LOCK, 1 LOCK_SETTLE, 2 HOLD, 3 RUN)
//   reset_count  out  number of exits from RUN, saturating at 255
module reset_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 65536,
    parameter int LOCK_SETTLE_CYCLES = 4096,
    parameter int RESET_HOLD_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       key_n,
    input  logic       sw_pol,
    output logic       rst_out_n,
    output logic [1:0] state,
    output logic [7:0] reset_count
);

    localparam int MAX_CYCLES =
        (DEBOUNCE_CYCLES > LOCK_SETTLE_CYCLES) ?
            ((DEBOUNCE_CYCLES > RESET_HOLD_CYCLES) ? DEBOUNCE_CYCLES : RESET_HOLD_CYCLES) :
            ((LOCK_SETTLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_SETTLE_CYCLES : RESET_HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    // Counters stop at these terminal values and restart from zero, so they never wrap.
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK   = 2'd0,
        LOCK_SETTLE = 2'd1,
        HOLD        = 2'd2,
        RUN         = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    logic             lock_meta, lock_sync;
    logic             key_meta,  key_sync;
    logic             pol_meta,  pol_sync;
    logic             raw_req;
    logic             req_db;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] phase_cnt;
    state_t           fsm;

    // Two-flop synchronisers for every asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            pol_meta  <= 1'b0;
            pol_sync  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
            key_meta  <= key_n;
            key_sync  <= key_meta;
            pol_meta  <= sw_pol;
            pol_sync  <= pol_meta;
        end
    end

    // sw_pol inverts the sense of the button, so sw_pol=1 with the key
    // released is a standing reset request.
    assign raw_req = ~key_sync ^ pol_sync;

    // Debounce: a new level is accepted only after it has disagreed with
    // req_db for DEBOUNCE_CYCLES consecutive cycles; one agreeing cycle restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_db <= 1'b0;
            db_cnt <= '0;
        end else if (raw_req == req_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            req_db <= raw_req;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_ONE;
        end
    end

    // Sequencing FSM. One phase counter serves both LOCK_SETTLE and HOLD
    // since they are never active together. rst_out_n is written alongside
    // every transition so it always equals (next state == RUN).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm         <= WAIT_LOCK;
            phase_cnt   <= '0;
            rst_out_n   <= 1'b0;
            reset_count <= 8'd0;
        end else if (!lock_sync) begin
            // Lock loss overrides everything else in every state.
            if (fsm == RUN) begin
                reset_count <= sat_inc(reset_count);
            end
            fsm       <= WAIT_LOCK;
            phase_cnt <= '0;
            rst_out_n <= 1'b0;
        end else begin
            case (fsm)
                WAIT_LOCK: begin
                    fsm       <= LOCK_SETTLE;
                    phase_cnt <= '0;
                    rst_out_n <= 1'b0;
                end
                LOCK_SETTLE: begin
                    rst_out_n <= 1'b0;
                    if (phase_cnt == SETTLE_LAST) begin
                        fsm       <= HOLD;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (req_db) begin
                        phase_cnt <= '0;
                        rst_out_n <= 1'b0;
                    end else if (phase_cnt == HOLD_LAST) begin
                        fsm       <= RUN;
                        phase_cnt <= '0;
                        rst_out_n <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                        rst_out_n <= 1'b0;
                    end
                end
                RUN: begin
                    if (req_db) begin
                        fsm         <= HOLD;
                        phase_cnt   <= '0;
                        rst_out_n   <= 1'b0;
                        reset_count <= sat_inc(reset_count);
                    end else begin
                        rst_out_n <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= WAIT_LOCK;
                    phase_cnt <= '0;
                    rst_out_n <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm;

endmodule

// File: tb/tb_reset_conditioner.sv
// tb_reset_conditioner
//   Directed scenarios followed by a randomised phase, all checked every
//   cycle against a duration-based reference model: the expected state is
//   derived from how long lock has been seen and how long the debounced
//   request has been quiet, not from a copy of the FSM.
module tb_reset_conditioner;

    localparam int DB = 4;
    localparam int LS = 8;
    localparam int RH = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       key_n;
    logic       sw_pol;
    logic       rst_out_n;
    logic [1:0] state;
    logic [7:0] reset_count;

    int vectors     = 0;
    int miscompares = 0;

    reset_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LOCK_SETTLE_CYCLES(LS),
        .RESET_HOLD_CYCLES (RH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .key_n      (key_n),
        .sw_pol     (sw_pol),
        .rst_out_n  (rst_out_n),
        .state      (state),
        .reset_count(reset_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit lock_h[2];
    bit key_h[2];
    bit pol_h[2];
    bit raw_hist[$];
    bit m_req_db;
    int lock_age;
    int quiet_age;
    int exp_state;
    int m_exits;
    int cyc;
    int db_fall_cyc;
    int lock_rise_cyc;

    function automatic int state_from_ages(input int a, input int q);
        if (a == 0)                          return 0;
        if (a <= LS)                         return 1;
        if (a >= LS + 1 + RH && q >= RH)     return 3;
        return 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lock_h[i] = 1'b0;
            key_h[i]  = 1'b0;
            pol_h[i]  = 1'b0;
        end
        raw_hist.delete();
        m_req_db  = 1'b0;
        lock_age  = 0;
        quiet_age = 0;
        exp_state = 0;
        m_exits   = 0;
    endtask

    task automatic model_step();
        bit ls, rawv, rdb, all_differ;
        int ns;
        cyc++;
        ls   = lock_h[1];
        rawv = !key_h[1] ^ pol_h[1];
        rdb  = m_req_db;
        lock_age  = ls  ? ((lock_age  < 1000000) ? lock_age  + 1 : lock_age)  : 0;
        quiet_age = rdb ? 0 : ((quiet_age < 1000000) ? quiet_age + 1 : quiet_age);
        ns = state_from_ages(lock_age, quiet_age);
        if (exp_state == 3 && ns != 3 && m_exits < 255) m_exits++;
        exp_state = ns;
        raw_hist.push_back(rawv);
        if (raw_hist.size() > DB) void'(raw_hist.pop_front());
        all_differ = (raw_hist.size() == DB);
        foreach (raw_hist[i]) if (raw_hist[i] == rdb) all_differ = 1'b0;
        if (all_differ) begin
            if (rdb && !rawv) db_fall_cyc = cyc;
            m_req_db = rawv;
        end
        if (!lock_h[1] && lock_h[0]) lock_rise_cyc = cyc;
        lock_h[1] = lock_h[0]; lock_h[0] = pll_locked;
        key_h[1]  = key_h[0];  key_h[0]  = key_n;
        pol_h[1]  = pol_h[0];  pol_h[0]  = sw_pol;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_outputs();
        chk("state", 32'(state), 32'(exp_state));
        chk("rst_out_n", 32'(rst_out_n), 32'(exp_state == 3));
        chk("reset_count", 32'(reset_count), 32'(m_exits));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_rst(input logic val, input int limit, output int n);
        n = 0;
        while (rst_out_n !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int n);
        n = 0;
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Called at a negedge: reset lands mid-cycle, outputs are checked before the next edge.
    task automatic async_reset_pulse(input string tag);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_rst_out_n"}, 32'(rst_out_n), 32'd0);
        chk({tag, "_count"}, 32'(reset_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, fall_at, rise_cyc;
        bit stayed;
        cyc = 0; db_fall_cyc = 0; lock_rise_cyc = 0;
        reset_n = 1'b0; pll_locked = 1'b1; key_n = 1'b1; sw_pol = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_rst_out_n", 32'(rst_out_n), 32'd0);
        chk("reset_count0", 32'(reset_count), 32'd0);

        // Power-up with lock present
        reset_n = 1'b1;
        wait_rst(1'b1, 40, n);
        chk_range("powerup_rise", n, 16, 18);
        chk("powerup_state", 32'(state), 32'd3);
        chk("powerup_count", 32'(reset_count), 32'd0);

        // Short press is filtered out
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        stayed = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rst_out_n !== 1'b1) stayed = 1'b0;
        end
        chk("short_press_run", 32'(stayed), 32'd1);
        chk("short_press_count", 32'(reset_count), 32'd0);

        // Long press resets the core
        key_n = 1'b0;
        fall_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fall_at == 0 && rst_out_n === 1'b0) fall_at = i;
        end
        key_n = 1'b1;
        chk_range("long_press_fall", fall_at, 6, 8);
        chk("long_press_count", 32'(reset_count), 32'd1);
        wait_rst(1'b1, 40, n);
        rise_cyc = cyc;
        chk("release_to_run", 32'(rise_cyc - db_fall_cyc), 32'd6);

        // One-cycle lock glitch
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_rst(1'b0, 5, n);
        chk_range("lock_loss_fall", n + 1, 1, 3);
        chk("lock_loss_state", 32'(state), 32'd0);
        wait_rst(1'b1, 40, n);
        rise_cyc = cyc;
        chk_range("lock_regain_rise", rise_cyc - lock_rise_cyc, 14, 16);
        chk("lock_loss_count", 32'(reset_count), 32'd2);

        // Inverted polarity holds the core in reset
        sw_pol = 1'b1;
        wait_state(2'd2, 20, n);
        repeat (10) tick();
        chk("pol_hold_state", 32'(state), 32'd2);
        chk("pol_hold_rst", 32'(rst_out_n), 32'd0);
        sw_pol = 1'b0;
        wait_rst(1'b1, 30, n);
        chk_range("pol_release_rise", n, 10, 13);

        // Saturate the exit counter
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            wait_rst(1'b0, 10, n);
            wait_rst(1'b1, 40, n);
            chk_range("exit_loop_rise", n, 1, 39);
        end
        chk("count_saturated", 32'(reset_count), 32'd255);

        // Reset pulse while in HOLD
        key_n = 1'b0;
        wait_state(2'd2, 20, n);
        chk("enter_hold", 32'(state), 32'd2);
        repeat (2) tick();
        async_reset_pulse("hold_reset");
        key_n = 1'b1;
        wait_rst(1'b1, 40, n);
        chk_range("resume_rise", n, 16, 18);

        // Randomised activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 8) key_n = ~key_n;
            if ($urandom_range(0, 199) < 2) sw_pol = ~sw_pol;
            if (pll_locked) begin
                if ($urandom_range(0, 199) < 2) pll_locked = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                pll_locked = 1'b1;
            end
            if ($urandom_range(0, 999) < 3) async_reset_pulse("random_reset");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
